// File: rtl/calc_ctrl_if.sv
// calc_ctrl_if: bundle of the key, ALU and display signals around calc_ctrl.
//   master : key source / ALU / display side (drives keys and ALU results)
//   slave  : the calc_ctrl controller (drives operands, start, display, status)
//   key_valid/key_code : one-cycle translated key event
//   alu_done/alu_res/alu_err : ALU result handshake
//   op_a/op_b/op_sel/alu_start : operation request to the ALU
//   disp_val/disp_op : display value and operator annunciator
//   state/busy/error : controller status
interface calc_ctrl_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        alu_done;
    logic [15:0] alu_res;
    logic        alu_err;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [1:0]  op_sel;
    logic        alu_start;
    logic [15:0] disp_val;
    logic [1:0]  disp_op;
    logic [2:0]  state;
    logic        busy;
    logic        error;

    modport master (
        output key_valid, key_code, alu_done, alu_res, alu_err,
        input  op_a, op_b, op_sel, alu_start, disp_val, disp_op, state, busy, error
    );

    modport slave (
        input  key_valid, key_code, alu_done, alu_res, alu_err,
        output op_a, op_b, op_sel, alu_start, disp_val, disp_op, state, busy, error
    );
endinterface

// File: rtl/calc_ctrl.sv
// calc_ctrl: keypad calculator sequencing controller. Assembles two 4-digit
// BCD operands and an operator from key events, runs the ALU start/done
// handshake with a timeout, and selects the display value.
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : calc_ctrl_if.slave (keys, ALU handshake, operands, display, status)
// Every output is a register; next-state values are computed combinationally
// and the display/status registers are loaded from those next values so they
// change on the same edge as the state.
module calc_ctrl #(
    parameter int ALU_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         resetn,
    calc_ctrl_if.slave   bus
);
    localparam logic [2:0] ST_ENTER_A  = 3'd0;
    localparam logic [2:0] ST_OP_WAIT  = 3'd1;
    localparam logic [2:0] ST_ENTER_B  = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_SHOW_RES = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

    localparam int              TW       = $clog2(ALU_TIMEOUT) + 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(ALU_TIMEOUT - 1);
    localparam logic [TW-1:0]   TMO_ONE  = TW'(1);
    localparam logic [TW-1:0]   TMO_ZERO = TW'(0);

    // Map an operator key to op_sel; non-operator keys map to 00.
    function automatic logic [1:0] op_decode(input logic [3:0] code);
        case (code)
            4'd10:   op_decode = 2'b01;
            4'd11:   op_decode = 2'b10;
            4'd14:   op_decode = 2'b11;
            default: op_decode = 2'b00;
        endcase
    endfunction

    // Shift one BCD digit into the least significant nibble.
    function automatic logic [15:0] shift_digit(input logic [15:0] val, input logic [3:0] digit);
        shift_digit = {val[11:0], digit};
    endfunction

    logic [2:0]    state_r, state_s;
    logic [15:0]   a_r, a_s, b_r, b_s, res_r, res_s, disp_r, disp_s;
    logic [1:0]    op_r, op_s;
    logic [2:0]    cnt_a_r, cnt_a_s, cnt_b_r, cnt_b_s;
    logic [TW-1:0] tmo_r, tmo_s;
    logic          start_r, start_s;
    logic          busy_r, error_r;
    logic          is_digit_s, is_op_s, is_clr_s, is_eq_s;

    assign is_digit_s = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_op_s    = bus.key_valid && (op_decode(bus.key_code) != 2'b00);
    assign is_clr_s   = bus.key_valid && (bus.key_code == 4'd12);
    assign is_eq_s    = bus.key_valid && (bus.key_code == 4'd13);

    // Next-state and datapath update for one accepted key / ALU event.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        b_s     = b_r;
        res_s   = res_r;
        op_s    = op_r;
        cnt_a_s = cnt_a_r;
        cnt_b_s = cnt_b_r;
        tmo_s   = tmo_r;
        start_s = 1'b0;
        if (is_clr_s) begin
            // Clear has priority over everything, including a same-cycle alu_done.
            state_s = ST_ENTER_A;
            a_s     = 16'h0000;
            b_s     = 16'h0000;
            res_s   = 16'h0000;
            op_s    = 2'b00;
            cnt_a_s = 3'd0;
            cnt_b_s = 3'd0;
            tmo_s   = TMO_ZERO;
        end else begin
            case (state_r)
                ST_ENTER_A: begin
                    if (is_digit_s && (cnt_a_r != 3'd4)) begin
                        a_s     = shift_digit(a_r, bus.key_code);
                        cnt_a_s = cnt_a_r + 3'd1;
                    end else if (is_op_s) begin
                        op_s    = op_decode(bus.key_code);
                        state_s = ST_OP_WAIT;
                    end else begin
                        state_s = ST_ENTER_A;
                    end
                end
                ST_OP_WAIT: begin
                    if (is_op_s) begin
                        op_s = op_decode(bus.key_code);
                    end else if (is_digit_s) begin
                        b_s     = {12'h000, bus.key_code};
                        cnt_b_s = 3'd1;
                        state_s = ST_ENTER_B;
                    end else begin
                        state_s = ST_OP_WAIT;
                    end
                end
                ST_ENTER_B: begin
                    if (is_digit_s && (cnt_b_r != 3'd4)) begin
                        b_s     = shift_digit(b_r, bus.key_code);
                        cnt_b_s = cnt_b_r + 3'd1;
                    end else if (is_eq_s) begin
                        state_s = ST_EXEC;
                        start_s = 1'b1;
                        tmo_s   = TMO_ZERO;
                    end else begin
                        state_s = ST_ENTER_B;
                    end
                end
                ST_EXEC: begin
                    // alu_done is not trusted during the start-pulse cycle.
                    tmo_s = tmo_r + TMO_ONE;
                    if (!start_r && bus.alu_done && !bus.alu_err) begin
                        res_s   = bus.alu_res;
                        state_s = ST_SHOW_RES;
                    end else if (!start_r && bus.alu_done) begin
                        state_s = ST_ERROR;
                    end else if (tmo_r == TMO_LAST) begin
                        state_s = ST_ERROR;
                    end else begin
                        state_s = ST_EXEC;
                    end
                end
                ST_SHOW_RES: begin
                    if (is_digit_s) begin
                        a_s     = {12'h000, bus.key_code};
                        b_s     = 16'h0000;
                        cnt_a_s = 3'd1;
                        op_s    = 2'b00;
                        state_s = ST_ENTER_A;
                    end else if (is_op_s) begin
                        // Chaining: the previous result becomes a full operand A.
                        a_s     = res_r;
                        cnt_a_s = 3'd4;
                        op_s    = op_decode(bus.key_code);
                        state_s = ST_OP_WAIT;
                    end else begin
                        state_s = ST_SHOW_RES;
                    end
                end
                ST_ERROR: begin
                    state_s = ST_ERROR;
                end
                default: begin
                    state_s = ST_ENTER_A;
                    a_s     = 16'h0000;
                    b_s     = 16'h0000;
                    res_s   = 16'h0000;
                    op_s    = 2'b00;
                    cnt_a_s = 3'd0;
                    cnt_b_s = 3'd0;
                    tmo_s   = TMO_ZERO;
                end
            endcase
        end
    end

    // Display selection from the next state so it updates with the state.
    always_comb begin
        disp_s = 16'h0000;
        case (state_s)
            ST_ENTER_A, ST_OP_WAIT: disp_s = a_s;
            ST_ENTER_B, ST_EXEC:    disp_s = b_s;
            ST_SHOW_RES:            disp_s = res_s;
            ST_ERROR:               disp_s = 16'hEEEE;
            default:                disp_s = 16'h0000;
        endcase
    end

    // Controller state and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_ENTER_A;
            a_r     <= 16'h0000;
            b_r     <= 16'h0000;
            res_r   <= 16'h0000;
            disp_r  <= 16'h0000;
            op_r    <= 2'b00;
            cnt_a_r <= 3'd0;
            cnt_b_r <= 3'd0;
            tmo_r   <= TMO_ZERO;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            b_r     <= b_s;
            res_r   <= res_s;
            disp_r  <= disp_s;
            op_r    <= op_s;
            cnt_a_r <= cnt_a_s;
            cnt_b_r <= cnt_b_s;
            tmo_r   <= tmo_s;
            start_r <= start_s;
            busy_r  <= (state_s == ST_EXEC);
            error_r <= (state_s == ST_ERROR);
        end
    end

    assign bus.op_a      = a_r;
    assign bus.op_b      = b_r;
    assign bus.op_sel    = op_r;
    assign bus.disp_op   = op_r;
    assign bus.alu_start = start_r;
    assign bus.disp_val  = disp_r;
    assign bus.state     = state_r;
    assign bus.busy      = busy_r;
    assign bus.error     = error_r;
endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the keypad calculator. Consumes one-cycle translated key events, assembles two 4-digit BCD operands and an operator, hands them to the ALU with a start/done handshake, and selects the value driven to the display. Sits between the key translation stage and the ALU/display, replacing separate save and event-FSM glue with one registered controller.

## Interface
- ALU_TIMEOUT, 64: cycles allowed in EXEC for alu_done before entering ERROR (≥2).
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- key_valid  input  1  one-cycle pulse; key_code is valid in this cycle.
- key_code  input  4  0–9 digit; 10 (A) add; 11 (B) subtract; 14 (*) multiply; 12 (C) clear; 13 (D) equals; 15 ignored.
- alu_done  input  1  ALU result valid (level or pulse).
- alu_res  input  16  ALU result, 4-digit BCD.
- alu_err  input  1  ALU special/overflow/negative flag; sampled with alu_done.
- op_a  output  16  operand A, BCD.
- op_b  output  16  operand B, BCD.
- op_sel  output  2  01 add, 10 sub, 11 mul, 00 none.
- alu_start  output  1  one-cycle pulse requesting an operation.
- disp_val  output  16  BCD value for the display.
- disp_op  output  2  operator annunciator; equals op_sel.
- state  output  3  ENTER_A=0, OP_WAIT=1, ENTER_B=2, EXEC=3, SHOW_RES=4, ERROR=5.
- busy  output  1  high in EXEC.
- error  output  1  high in ERROR.

## Operation
- All outputs are registered. Reset value is 0 for every output, state=ENTER_A, and digit counters cnt_a=cnt_b=0.
- Digit entry: operand <= {operand[11:0], digit}; cnt++. When cnt=4, further digits are dropped and the operand is unchanged.
- ENTER_A: a digit shifts into A. An operator latches op_sel and moves to OP_WAIT; A=0 is allowed if no digits were entered. D is ignored.
- OP_WAIT: another operator replaces op_sel. A digit clears B, loads it with that digit, sets cnt_b=1, and moves to ENTER_B. D is ignored.
- ENTER_B: a digit shifts into B. An operator is ignored. D moves to EXEC and pulses alu_start.
- EXEC: all keys except C are ignored. When alu_done=1 and alu_err=0, the result is latched and the state moves to SHOW_RES. When alu_done=1 and alu_err=1, the state moves to ERROR. If the timeout counter reaches ALU_TIMEOUT, the state moves to ERROR.
- SHOW_RES: a digit sets A to that digit, B to 0, cnt_a=1, op_sel=00, and moves to ENTER_A. An operator sets A to the result, cnt_a=4, latches op_sel, and moves to OP_WAIT (chaining). D is ignored.
- ERROR: only C is accepted.
- C in any state clears A, B, result, op_sel and both counters, and moves to ENTER_A.
- disp_val by state: A in ENTER_A and OP_WAIT; B in ENTER_B and EXEC; the result in SHOW_RES; 16'hEEEE in ERROR.
- Key code 15 and key_valid=0 produce no change in any state.

## Timing
- A key is accepted on the edge where key_valid=1. The register and state update is visible the following cycle, so display latency is 1 cycle.
- alu_start rises on the edge that accepts D. It is high for exactly one cycle and falls on the next edge. op_a, op_b and op_sel are stable from the start pulse until the state leaves EXEC.
- alu_done is ignored while alu_start=1. It is sampled on each later edge in EXEC. The result appears on disp_val the cycle after alu_done is sampled.
- The timeout counter clears on EXEC entry and increments every EXEC cycle. ERROR is entered on the edge where the count equals ALU_TIMEOUT−1 with no alu_done.
- Simultaneous C and alu_done in EXEC: C wins, the result is discarded, and the state goes to ENTER_A.
- alu_done arriving outside EXEC, including late after a timeout or C, is ignored.
- resetn low mid-operation: all registers clear immediately (asynchronous). alu_start drops without waiting for a clock. Operation resumes in ENTER_A on the first edge after resetn rises.

## Test plan
- Keys 1,2,A,3,4,D with the ALU returning alu_res=16'h0046 and alu_done two cycles after start:
  - op_a=0x0012, op_b=0x0034, op_sel=01.
  - Exactly one alu_start pulse.
  - disp_val=0x0046 and state=4 the cycle after alu_done.
- Keys 9,8,7,6,5 in ENTER_A -> op_a=0x9876 and the fifth digit is dropped. Keys A,B -> op_sel=10 and state=1.
- SHOW_RES with result 0x0046, then keys *,2,D -> op_a=0x0046, op_sel=11, op_b=0x0002, and a second alu_start pulse.
- Keys 5,A,3,D with alu_done never asserted (ALU_TIMEOUT=64):
  - busy is high for 64 cycles, then error=1 and disp_val=0xEEEE.
  - A later alu_done has no effect.
  - C returns to state=0 with all operands 0.
- C and alu_done in the same cycle during EXEC -> state=0, disp_val=0, result not latched.
- resetn pulsed low during EXEC the cycle alu_start=1 -> alu_start=0 immediately, all outputs 0, state=0. Key 7 after release -> op_a=0x0007.
